vgroup_sequencer: RTL

//  Consumer side of the vector control-unit decode interface (valu_op/valu_src/vRegWrite/grouping_enable).

---
 rtl/vgroup_sequencer_pkg.sv | 41 ++++
 rtl/vgroup_sequencer_align.sv | 36 +++
 rtl/vgroup_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/vgroup_sequencer_pkg.sv
// Shared encodings for the vector group sequencer: VALU opcodes,
// operand-source selects, vlmul codes and the vlmul -> group-size map.
package vgroup_sequencer_pkg;

  localparam logic [3:0] VALU_ADD     = 4'h0;
  localparam logic [3:0] VALU_SUB     = 4'h1;
  localparam logic [3:0] VALU_AND     = 4'h2;
  localparam logic [3:0] VALU_OR      = 4'h3;
  localparam logic [3:0] VALU_XOR     = 4'h4;
  localparam logic [3:0] VALU_INVALID = 4'hF;

  localparam logic [1:0] SRC_VV   = 2'b00;
  localparam logic [1:0] SRC_VX   = 2'b01;
  localparam logic [1:0] SRC_VI   = 2'b10;
  localparam logic [1:0] SRC_NONE = 2'b11;

  localparam logic [2:0] VLMUL_1 = 3'b000;
  localparam logic [2:0] VLMUL_2 = 3'b001;
  localparam logic [2:0] VLMUL_4 = 3'b010;
  localparam logic [2:0] VLMUL_8 = 3'b011;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] src;
  } uop_ctl_t;

  // Fractional LMUL still occupies one whole register.
  function automatic logic [3:0] vlmul_to_g(
    input logic [2:0] vlmul,
    input logic       grp_en
  );
    if (!grp_en || vlmul[2]) return 4'd1;
    return 4'd1 << vlmul[1:0];
  endfunction

endpackage

// File: rtl/vgroup_sequencer_align.sv
// Group-size decode and register-group alignment check.
// Purely combinational; used by the sequencer at accept time.
module vgroup_align_check
  import vgroup_sequencer_pkg::*;
#(
  parameter int REG_IDX_W = 5,
  parameter int MAX_GRP   = 8
) (
  input  logic [2:0]           vlmul,
  input  logic                 grouping_enable,
  input  logic                 vv,
  input  logic [REG_IDX_W-1:0] vd,
  input  logic [REG_IDX_W-1:0] vs1,
  input  logic [REG_IDX_W-1:0] vs2,
  output logic [3:0]           grp,
  output logic                 aligned
);

  logic [REG_IDX_W-1:0] mask;
  logic                 fits;
  logic                 vd_ok;
  logic                 vs1_ok;
  logic                 vs2_ok;

  assign grp  = vlmul_to_g(vlmul, grouping_enable);
  assign mask = REG_IDX_W'(grp - 4'd1);
  assign fits = int'(grp) <= MAX_GRP;

  assign vd_ok  = (vd & mask) == '0;
  assign vs2_ok = (vs2 & mask) == '0;
  // vs1 is a scalar/imm field unless both sources are vregs.
  assign vs1_ok = !vv || ((vs1 & mask) == '0);

  assign aligned = fits && vd_ok && vs1_ok && vs2_ok;

endmodule

// File: rtl/vgroup_sequencer.sv
// Expands one decoded vector instruction into per-register VALU
// micro-ops walking the LMUL register group.
module vgroup_sequencer
  import vgroup_sequencer_pkg::*;
#(
  parameter int REG_IDX_W = 5,
  parameter int SCALAR_W  = 32,
  parameter int MAX_GRP   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic                 vRegWrite,
  input  logic [3:0]           valu_op,
  input  logic [1:0]           valu_src,
  input  logic                 grouping_enable,
  input  logic [2:0]           vlmul,
  input  logic [REG_IDX_W-1:0] vd,
  input  logic [REG_IDX_W-1:0] vs1,
  input  logic [REG_IDX_W-1:0] vs2,
  input  logic [SCALAR_W-1:0]  scalar_in,
  output logic                 uop_valid,
  input  logic                 uop_ready,
  output logic [3:0]           uop_op,
  output logic [1:0]           uop_src,
  output logic [REG_IDX_W-1:0] uop_vd,
  output logic [REG_IDX_W-1:0] uop_vs1,
  output logic [REG_IDX_W-1:0] uop_vs2,
  output logic [SCALAR_W-1:0]  uop_scalar,
  output logic                 uop_we,
  output logic                 uop_last,
  output logic                 op_done,
  output logic                 illegal
);

  localparam int IDX_W = (MAX_GRP > 1) ? $clog2(MAX_GRP) : 1;

  state_t               state_q;
  state_t               state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     idx_d;
  logic [IDX_W-1:0]     last_q;
  uop_ctl_t             ctl_q;
  logic [REG_IDX_W-1:0] vd_q;
  logic [REG_IDX_W-1:0] vs1_q;
  logic [REG_IDX_W-1:0] vs2_q;
  logic [SCALAR_W-1:0]  scalar_q;
  logic                 done_q;
  logic                 done_d;
  logic                 illegal_q;
  logic                 illegal_d;
  logic                 load;
  logic [3:0]           grp;
  logic                 aligned;
  logic [REG_IDX_W-1:0] idx_ext;

  vgroup_align_check #(
    .REG_IDX_W (REG_IDX_W),
    .MAX_GRP   (MAX_GRP)
  ) u_align (
    .vlmul           (vlmul),
    .grouping_enable (grouping_enable),
    .vv              (valu_src == SRC_VV),
    .vd              (vd),
    .vs1             (vs1),
    .vs2             (vs2),
    .grp             (grp),
    .aligned         (aligned)
  );

  assign issue_ready = state_q == ST_IDLE;
  assign uop_valid   = state_q == ST_RUN;
  assign uop_we      = uop_valid;
  assign uop_last    = uop_valid && (idx_q == last_q);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (issue_valid) begin
          if (!vRegWrite || valu_src == SRC_NONE) begin
            done_d = 1'b1;
          end else if (valu_op == VALU_INVALID || !aligned) begin
            illegal_d = 1'b1;
          end else begin
            load    = 1'b1;
            idx_d   = '0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (uop_ready) begin
          if (uop_last) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      ctl_q     <= '0;
      vd_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      scalar_q  <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      if (load) begin
        last_q    <= IDX_W'(grp - 4'd1);
        ctl_q.op  <= valu_op;
        ctl_q.src <= valu_src;
        vd_q      <= vd;
        vs1_q     <= vs1;
        vs2_q     <= vs2;
        scalar_q  <= scalar_in;
      end
    end
  end

  assign idx_ext    = REG_IDX_W'(idx_q);
  assign uop_op     = ctl_q.op;
  assign uop_src    = ctl_q.src;
  assign uop_vd     = vd_q + idx_ext;
  assign uop_vs2    = vs2_q + idx_ext;
  assign uop_vs1    = (ctl_q.src == SRC_VV) ? vs1_q + idx_ext : vs1_q;
  assign uop_scalar = scalar_q;
  assign op_done    = done_q;
  assign illegal    = illegal_q;

endmodule
